// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - match phase/winner encodings and default timing constants
package fighter_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_INTRO = 3'd1,
    PH_FIGHT = 3'd2,
    PH_KO    = 3'd3,
    PH_OVER  = 3'd4
  } match_phase_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'd0,
    WIN_RYU   = 2'd1,
    WIN_AKUMA = 2'd2,
    WIN_DRAW  = 2'd3
  } winner_t;

  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_ROUND_TIME     = 99;
  localparam int DEF_INTRO_FRAMES   = 120;
  localparam int DEF_KO_FRAMES      = 180;
  localparam int DEF_ROUNDS_TO_WIN  = 2;
  localparam int DEF_MAX_ROUNDS     = 5;

  // Larger value wins; a tie is a draw. Used for timeouts and the final match result.
  function automatic winner_t rank_pair(input logic [7:0] ryu_v, input logic [7:0] akuma_v);
    if (ryu_v > akuma_v)      return WIN_RYU;
    else if (akuma_v > ryu_v) return WIN_AKUMA;
    else                      return WIN_DRAW;
  endfunction

endpackage

// File: rtl/round_timer.sv
// rtl/round_timer.sv - frame counter plus saturating seconds countdown for one round
module round_timer
  import fighter_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int ROUND_TIME     = DEF_ROUND_TIME
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       enable_i,
  output logic [6:0] sec_o,
  output logic       expired_o
);

  localparam int FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);

  logic [FW-1:0] frame_q;
  logic [6:0]    sec_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
      sec_q   <= 7'(ROUND_TIME);
    end else if (load_i) begin
      frame_q <= '0;
      sec_q   <= 7'(ROUND_TIME);
    end else if (enable_i) begin
      if (frame_q == FRAME_LAST) begin
        frame_q <= '0;
        if (sec_q != 7'd0) sec_q <= sec_q - 7'd1;
      end else begin
        frame_q <= frame_q + FW'(1);
      end
    end
  end

  assign sec_o     = sec_q;
  assign expired_o = (sec_q == 7'd0);

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - fight match sequencer; MATCH_TIMER_EN enables the round countdown/timeout
module match_ctrl
  import fighter_pkg::*;
#(
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int ROUND_TIME     = DEF_ROUND_TIME,
  parameter int INTRO_FRAMES   = DEF_INTRO_FRAMES,
  parameter int KO_FRAMES      = DEF_KO_FRAMES,
  parameter int ROUNDS_TO_WIN  = DEF_ROUNDS_TO_WIN,
  parameter int MAX_ROUNDS     = DEF_MAX_ROUNDS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       start,
  input  logic [7:0] ryu_health,
  input  logic [7:0] akuma_health,
  output logic       freeze,
  output logic       round_reset,
  output logic [2:0] phase,
  output logic [6:0] timer_sec,
  output logic [2:0] round_num,
  output logic [1:0] ryu_wins,
  output logic [1:0] akuma_wins,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  // One hold counter serves both freezes; sized for the longest count in use.
  localparam int HOLD_MAX = (INTRO_FRAMES > KO_FRAMES) ?
                            ((INTRO_FRAMES > FRAMES_PER_SEC) ? INTRO_FRAMES : FRAMES_PER_SEC) :
                            ((KO_FRAMES > FRAMES_PER_SEC) ? KO_FRAMES : FRAMES_PER_SEC);
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] INTRO_LAST = HW'(INTRO_FRAMES - 1);
  localparam logic [HW-1:0] KO_LAST    = HW'(KO_FRAMES - 1);
  localparam logic [1:0]    WINS_MAX   = 2'(ROUNDS_TO_WIN);
  localparam logic [2:0]    ROUND_MAX  = 3'(MAX_ROUNDS);

  match_phase_t  state_q;
  logic [HW-1:0] hold_q;
  logic          start_q, start_edge;
  logic          freeze_q, round_reset_q;
  logic [2:0]    round_num_q;
  logic [1:0]    ryu_wins_q, akuma_wins_q;
  winner_t       round_winner_q, match_winner_q, result_d;
  logic          timer_expired;

  assign start_edge = start & ~start_q;

`ifdef MATCH_TIMER_EN
  logic timer_load, timer_en;
  assign timer_load = (state_q == PH_INTRO) && (hold_q == INTRO_LAST);
  assign timer_en   = (state_q == PH_FIGHT);

  round_timer #(
    .FRAMES_PER_SEC(FRAMES_PER_SEC),
    .ROUND_TIME    (ROUND_TIME)
  ) u_round_timer (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .load_i   (timer_load),
    .enable_i (timer_en),
    .sec_o    (timer_sec),
    .expired_o(timer_expired)
  );
`else
  assign timer_sec     = 7'(ROUND_TIME);
  assign timer_expired = 1'b0;
`endif

  // KO is checked before the timeout so it decides a same-cycle tie.
  always_comb begin
    result_d = WIN_NONE;
    if (ryu_health == 8'd0 && akuma_health == 8'd0) result_d = WIN_DRAW;
    else if (akuma_health == 8'd0)                  result_d = WIN_RYU;
    else if (ryu_health == 8'd0)                    result_d = WIN_AKUMA;
    else if (timer_expired)                         result_d = rank_pair(ryu_health, akuma_health);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= PH_IDLE;
      hold_q         <= '0;
      start_q        <= 1'b0;
      freeze_q       <= 1'b1;
      round_reset_q  <= 1'b0;
      round_num_q    <= 3'd1;
      ryu_wins_q     <= 2'd0;
      akuma_wins_q   <= 2'd0;
      round_winner_q <= WIN_NONE;
      match_winner_q <= WIN_NONE;
    end else begin
      start_q       <= start;
      round_reset_q <= 1'b0;
      case (state_q)
        PH_IDLE: begin
          if (start_edge) begin
            state_q       <= PH_INTRO;
            hold_q        <= '0;
            round_reset_q <= 1'b1;
          end
        end
        PH_INTRO: begin
          if (hold_q == INTRO_LAST) begin
            state_q  <= PH_FIGHT;
            hold_q   <= '0;
            freeze_q <= 1'b0;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        PH_FIGHT: begin
          if (result_d != WIN_NONE) begin
            state_q        <= PH_KO;
            hold_q         <= '0;
            freeze_q       <= 1'b1;
            round_winner_q <= result_d;
            if (result_d == WIN_RYU && ryu_wins_q != WINS_MAX)
              ryu_wins_q <= ryu_wins_q + 2'd1;
            if (result_d == WIN_AKUMA && akuma_wins_q != WINS_MAX)
              akuma_wins_q <= akuma_wins_q + 2'd1;
          end
        end
        PH_KO: begin
          if (hold_q == KO_LAST) begin
            hold_q <= '0;
            if (ryu_wins_q == WINS_MAX || akuma_wins_q == WINS_MAX || round_num_q == ROUND_MAX) begin
              state_q        <= PH_OVER;
              match_winner_q <= rank_pair({6'd0, ryu_wins_q}, {6'd0, akuma_wins_q});
            end else begin
              state_q       <= PH_INTRO;
              round_num_q   <= round_num_q + 3'd1;
              round_reset_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        PH_OVER: begin
          if (start_edge) begin
            state_q        <= PH_INTRO;
            hold_q         <= '0;
            round_reset_q  <= 1'b1;
            round_num_q    <= 3'd1;
            ryu_wins_q     <= 2'd0;
            akuma_wins_q   <= 2'd0;
            round_winner_q <= WIN_NONE;
            match_winner_q <= WIN_NONE;
          end
        end
        default: begin
          state_q  <= PH_IDLE;
          freeze_q <= 1'b1;
        end
      endcase
    end
  end

  assign phase        = state_q;
  assign freeze       = freeze_q;
  assign round_reset  = round_reset_q;
  assign round_num    = round_num_q;
  assign ryu_wins     = ryu_wins_q;
  assign akuma_wins   = akuma_wins_q;
  assign round_winner = round_winner_q;
  assign match_winner = match_winner_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - randomized match play checked against a round/match rule model
module tb_match_ctrl;

  localparam int INTRO = 120;
  localparam int KOF   = 180;
  localparam int RT    = 99;
  localparam int FPS   = 60;
  localparam int RTW   = 2;
  localparam int MAXR  = 5;

  logic       Clk = 1'b0;
  logic       Reset, start;
  logic [7:0] ryu_health, akuma_health;
  logic       freeze, round_reset;
  logic [2:0] phase, round_num;
  logic [6:0] timer_sec;
  logic [1:0] ryu_wins, akuma_wins, round_winner, match_winner;

  int n_total = 0;
  int n_bad   = 0;
  int m_rw, m_aw, m_round;
  bit m_over;

  match_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .ryu_health  (ryu_health),
    .akuma_health(akuma_health),
    .freeze      (freeze),
    .round_reset (round_reset),
    .phase       (phase),
    .timer_sec   (timer_sec),
    .round_num   (round_num),
    .ryu_wins    (ryu_wins),
    .akuma_wins  (akuma_wins),
    .round_winner(round_winner),
    .match_winner(match_winner)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [7:0] rnz();
    return 8'($urandom_range(1, 255));
  endfunction

  function automatic logic [7:0] rany();
    return ($urandom_range(0, 3) == 0) ? 8'd0 : rnz();
  endfunction

  // Round result rules: KO beats timeout, double KO draws, timeout compares health.
  function automatic int ref_round(input int rh, input int ah, input bit tmo);
    if (rh == 0 && ah == 0) return 3;
    if (ah == 0) return 1;
    if (rh == 0) return 2;
    if (tmo) return (rh > ah) ? 1 : (ah > rh) ? 2 : 3;
    return 0;
  endfunction

  function automatic int ref_match(input int rw, input int aw);
    return (rw > aw) ? 1 : (aw > rw) ? 2 : 3;
  endfunction

  task automatic run_intro();
    check("intro_round_reset", round_reset, 1);
    check("intro_phase", phase, 1);
    check("intro_round_num", round_num, m_round);
    check("intro_freeze", freeze, 1);
    ryu_health   = rany();
    akuma_health = rany();
    tick();
    check("round_reset_one_cycle", round_reset, 0);
    ticks(INTRO - 2);
    check("intro_hold", phase, 1);
    ryu_health   = rany();
    akuma_health = rany();
    tick();
    check("fight_phase", phase, 2);
    check("fight_freeze", freeze, 0);
    check("fight_timer", timer_sec, RT);
    ryu_health   = rnz();
    akuma_health = rnz();
  endtask

  task automatic close_round(input int w);
    if (w == 1) m_rw++;
    else if (w == 2) m_aw++;
    check("ko_phase", phase, 3);
    check("ko_round_winner", round_winner, w);
    check("ko_ryu_wins", ryu_wins, m_rw);
    check("ko_akuma_wins", akuma_wins, m_aw);
    check("ko_freeze", freeze, 1);
    ryu_health   = rany();
    akuma_health = rany();
    ticks(KOF - 1);
    check("ko_hold", phase, 3);
    tick();
    if (m_rw == RTW || m_aw == RTW || m_round == MAXR) begin
      m_over = 1'b1;
      check("over_phase", phase, 4);
      check("over_match_winner", match_winner, ref_match(m_rw, m_aw));
      check("over_freeze", freeze, 1);
      check("over_round_reset", round_reset, 0);
    end else begin
      m_round++;
      run_intro();
    end
  endtask

  task automatic play_round(input int kind);
    int rh, ah, w;
    rh = ryu_health;
    ah = akuma_health;
    if (kind >= 3) begin
      rh = 50;
      ah = 30;
      ryu_health   = 8'(rh);
      akuma_health = 8'(ah);
      ticks(RT * FPS);
      check("timeout_timer_zero", timer_sec, 0);
      check("timeout_still_fight", phase, 2);
      if (kind == 4) rh = 0;
      ryu_health = 8'(rh);
      w = ref_round(rh, ah, 1'b1);
    end else begin
      ticks($urandom_range(0, 30));
      check("fight_hold", phase, 2);
      if (kind == 0 || kind == 2) ah = 0;
      if (kind == 1 || kind == 2) rh = 0;
      ryu_health   = 8'(rh);
      akuma_health = 8'(ah);
      w = ref_round(rh, ah, 1'b0);
    end
    tick();
    close_round(w);
  endtask

  function automatic int pick_kind(input int m, input int r);
    int v;
    if (m == 0 && r <= 2) return 0;
    if (m == 2 && r == 1) return 2;
`ifdef MATCH_TIMER_EN
    if (m == 1 && r == 1) return 3;
    if (m == 1 && r == 2) return 4;
`endif
    v = $urandom_range(0, 9);
    return (v < 4) ? 0 : (v < 8) ? 1 : 2;
  endfunction

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    ryu_health   = 8'd0;
    akuma_health = 8'd0;
    ticks(2);
    check("rst_phase", phase, 0);
    check("rst_freeze", freeze, 1);
    check("rst_round_reset", round_reset, 0);
    check("rst_timer", timer_sec, RT);
    check("rst_round_num", round_num, 1);
    check("rst_wins", {ryu_wins, akuma_wins}, 0);
    check("rst_winners", {round_winner, match_winner}, 0);
    Reset = 1'b0;
    tick();
    check("idle_wait", phase, 0);

    m_rw = 0; m_aw = 0; m_round = 1;
    start = 1'b1;
    tick();
    run_intro();

    for (int m = 0; m < 4; m++) begin
      m_over = 1'b0;
      for (int r = 1; r <= MAXR && !m_over; r++) play_round(pick_kind(m, r));
      if (!m_over) check("match_never_ended", 0, 1);
      ticks(3);
      check("over_ignores_start_level", phase, 4);
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      m_rw = 0; m_aw = 0; m_round = 1;
      check("restart_wins", {ryu_wins, akuma_wins}, 0);
      check("restart_winners", {round_winner, match_winner}, 0);
      run_intro();
    end

    m_over = 1'b0;
    play_round(0);
    ticks(5);
    #2;
    Reset = 1'b1;
    start = 1'b0;
    #1;
    check("midrst_phase", phase, 0);
    check("midrst_ryu_wins", ryu_wins, 0);
    check("midrst_freeze", freeze, 1);
    check("midrst_round_num", round_num, 1);
    check("midrst_round_winner", round_winner, 0);
    ticks(3);
    Reset = 1'b0;
    ticks(5);
    check("midrst_idle_wait", phase, 0);
    check("midrst_no_win", ryu_wins, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/match_ctrl.md
MATCH_CTRL -- requirements
Module: match_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- FRAMES_PER_SEC, 60, Clk cycles per timer second.
- ROUND_TIME, 99, starting round time in seconds.
- INTRO_FRAMES, 120, freeze length before a fight.
- KO_FRAMES, 180, freeze length after a round ends.
- ROUNDS_TO_WIN, 2, round wins that end the match.
- MAX_ROUNDS, 5, hard cap on rounds per match.

REQ-002 Ports (name, direction, width, meaning), one per line:
- Clk, in, 1, frame clock (VGA vertical sync); the block has one clock.
- Reset, in, 1, asynchronous, active-high.
- start, in, 1, start button level.
- ryu_health, in, 8, P1 health bar value.
- akuma_health, in, 8, P2 health bar value.
- freeze, out, 1, disables fighter movement and punches.
- round_reset, out, 1, one-cycle pulse that reloads health and positions.
- phase, out, 3, current state encoding.
- timer_sec, out, 7, remaining seconds.
- round_num, out, 3, current round, 1-based.
- ryu_wins, out, 2, P1 round wins.
- akuma_wins, out, 2, P2 round wins.
- round_winner, out, 2, result of last round: 0 none, 1 Ryu, 2 Akuma, 3 draw.
- match_winner, out, 2, same encoding as round_winner.

Function
REQ-003 States: IDLE=0, INTRO=1, FIGHT=2, KO=3, OVER=4.
REQ-004 A start edge is start high while a registered copy of start is low; only edges act, levels do not.
REQ-005 IDLE->INTRO on a start edge; round_reset pulses in the cycle INTRO is entered.
REQ-006 INTRO: freeze=1; after INTRO_FRAMES cycles the state goes to FIGHT, with timer_sec=ROUND_TIME and the frame counter at 0.
REQ-007 FIGHT: freeze=0; the frame counter counts 0..FRAMES_PER_SEC-1; on its wrap timer_sec decrements, saturating at 0.
REQ-008 FIGHT KO check each cycle. A fighter is KO'd when its health is 0. If exactly one fighter is KO'd, the other wins the round. If both are KO'd, the round is a draw (round_winner=3).
REQ-009 FIGHT timeout: when timer_sec==0, the higher health wins the round; equal health is a draw.
REQ-010 If a KO and a timeout occur in the same cycle, KO decides the result.
REQ-011 On a round end: the state goes to KO; round_winner is registered; the winner's wins counter increments. A draw increments neither counter.
REQ-012 KO: freeze=1 for KO_FRAMES cycles, then:
- if either wins==ROUNDS_TO_WIN or round_num==MAX_ROUNDS, go to OVER;
- otherwise go to INTRO, with round_num+1 and a round_reset pulse.
REQ-013 OVER: freeze=1. match_winner is the side with more wins; equal wins gives 3. A start edge clears the wins, sets round_num=1, clears both winner outputs and goes to INTRO.
REQ-014 Health inputs are ignored outside FIGHT.
REQ-015 The wins counters never exceed ROUNDS_TO_WIN; round_num never exceeds MAX_ROUNDS.
REQ-016 All outputs are registered; the state transition and its output changes take effect on the same Clk edge.

Reset
REQ-017 Reset asserted gives, asynchronously:
- phase=IDLE, freeze=1, round_reset=0;
- timer_sec=ROUND_TIME, round_num=1;
- both wins counters=0, both winner outputs=0;
- all internal counters and the start register cleared.
REQ-018 Reset asserted mid-round aborts the round with no win recorded; the block waits in IDLE.

Configuration
REQ-019 Macro MATCH_TIMER_EN. When defined, the countdown and timeout of REQ-007 and REQ-009 are active. When undefined, timer_sec is held at ROUND_TIME, no timeout occurs and the frame counter is not built; rounds end only by KO.

Structure
REQ-020 Package fighter_pkg holds:
- the match_phase_t enum;
- the winner_t encoding (NONE/RYU/AKUMA/DRAW);
- the default parameter constants.
REQ-021 Sub-module round_timer is the frame counter plus seconds countdown. It has load, enable and expired outputs, and is instantiated only under MATCH_TIMER_EN.

Verification
REQ-022 Scenarios (stimulus -> required response):
- Reset, then start edge -> round_reset high 1 cycle; phase=1; after 120 cycles phase=2, freeze=0, timer_sec=99.
- FIGHT, akuma_health=0, ryu_health=40 -> next edge phase=3, round_winner=1, ryu_wins=1; after 180 cycles phase=1, round_num=2, round_reset pulses.
- Ryu wins rounds 1 and 2 -> phase=4, match_winner=1, freeze=1; start edge -> wins=0, round_num=1, phase=1.
- Both healths 0 in the same cycle -> round_winner=3, both wins unchanged.
- MATCH_TIMER_EN, no KO, 99*60 cycles with health 50/30 -> timer_sec=0, round_winner=1. In the same cycle with ryu_health=0 -> round_winner=2, since KO has precedence.
- Reset pulse during FIGHT with ryu_wins=1 -> phase=0, ryu_wins=0, freeze=1 immediately, before any Clk edge.
